serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 129 ++++++++++++
 tb/tb_serial_subtractor.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: {bo, d} = a - b - bi, one bit per clock, LSB first.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow output ovf_o.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             bi_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] d_o,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   output logic             ovf_o,
`endif
   output logic             bo_o
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic             br_q, br_d;
   logic             bo_q, bo_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             diff_bit;
   logic             br_next;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      r_d      = r_q;
      d_d      = d_q;
      br_d     = br_q;
      bo_d     = bo_q;
      cnt_d    = cnt_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf_d    = ovf_q;
`endif
      diff_bit = a_q[0] ^ b_q[0] ^ br_q;
      br_next  = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);

      case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               a_d     = a_i;
               b_d     = b_i;
               br_d    = bi_i;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d            = a_q >> 1;
            b_d            = b_q >> 1;
            r_d            = r_q >> 1;
            r_d[WIDTH-1]   = diff_bit;
            br_d           = br_next;
            cnt_d          = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               // d_o is a separate register so it stays put while the next result shifts in
               d_d     = r_d;
               bo_d    = br_next;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
               // On the last bit a_q[0]/b_q[0] are the load-time MSBs and diff_bit is D[MSB]
               ovf_d   = (a_q[0] != b_q[0]) & (diff_bit != a_q[0]);
`endif
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         d_q     <= '0;
         br_q    <= 1'b0;
         bo_q    <= 1'b0;
         cnt_q   <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         d_q     <= d_d;
         br_q    <= br_d;
         bo_q    <= bo_d;
         cnt_q   <= cnt_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign in_ready_o  = (state_q == IDLE);
   assign out_valid_o = (state_q == DONE);
   assign d_o         = d_q;
   assign bo_o        = bo_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   assign ovf_o       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH 1, 8 and 13 against an integer arithmetic model.
// Honours SERIAL_SUBTRACTOR_OVF_EN when the design is built with it.
module tb_serial_subtractor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  iv, ordy, bi_s;
   logic [12:0] a_s [3];
   logic [12:0] b_s [3];
   wire  [2:0]  ir, ov, bo;
   wire  [0:0]  d0;
   wire  [7:0]  d1;
   wire  [12:0] d2;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   wire  [2:0]  ovf;
`endif
   int          wid [3] = '{1, 8, 13};
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(1)) u_w1 (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv[0]), .in_ready_o(ir[0]),
      .a_i(a_s[0][0:0]), .b_i(b_s[0][0:0]), .bi_i(bi_s[0]),
      .out_valid_o(ov[0]), .out_ready_i(ordy[0]), .d_o(d0),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      .ovf_o(ovf[0]),
`endif
      .bo_o(bo[0]));

   serial_subtractor #(.WIDTH(8)) u_w8 (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv[1]), .in_ready_o(ir[1]),
      .a_i(a_s[1][7:0]), .b_i(b_s[1][7:0]), .bi_i(bi_s[1]),
      .out_valid_o(ov[1]), .out_ready_i(ordy[1]), .d_o(d1),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      .ovf_o(ovf[1]),
`endif
      .bo_o(bo[1]));

   serial_subtractor #(.WIDTH(13)) u_w13 (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv[2]), .in_ready_o(ir[2]),
      .a_i(a_s[2]), .b_i(b_s[2]), .bi_i(bi_s[2]),
      .out_valid_o(ov[2]), .out_ready_i(ordy[2]), .d_o(d2),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      .ovf_o(ovf[2]),
`endif
      .bo_o(bo[2]));

   function automatic logic [31:0] get_d(int k);
      case (k)
         0:       return {31'b0, d0};
         1:       return {24'b0, d1};
         default: return {19'b0, d2};
      endcase
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_vals(string tag);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s_w%0d_in_ready", tag, wid[k]), 32'(ir[k]), 1);
         chk($sformatf("%s_w%0d_out_valid", tag, wid[k]), 32'(ov[k]), 0);
         chk($sformatf("%s_w%0d_d", tag, wid[k]), get_d(k), 0);
         chk($sformatf("%s_w%0d_bo", tag, wid[k]), 32'(bo[k]), 0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
         chk($sformatf("%s_w%0d_ovf", tag, wid[k]), 32'(ovf[k]), 0);
`endif
      end
   endtask

   // Offer operands (with random pre-stall), returns 1 once the accepting edge has passed.
   task automatic send(int k, logic [12:0] a, logic [12:0] b, logic bi, int stall_max,
                       string tag, output bit ok);
      bit acc = 0;
      repeat ($urandom_range(0, stall_max)) tick();
      iv[k] = 1'b1; a_s[k] = a; b_s[k] = b; bi_s[k] = bi;
      for (int c = 0; c < 64 && !acc; c++) begin
         acc = ir[k];
         tick();
      end
      iv[k] = 1'b0;
      a_s[k] = 13'($urandom); b_s[k] = 13'($urandom); bi_s[k] = 1'($urandom);
      ok = acc;
      if (!acc) chk({tag, "_accept_timeout"}, 0, 1);
   endtask

   // One full transaction; hold>0 keeps out_ready low for hold cycles while offering junk operands.
   task automatic txn(int k, logic [12:0] a_in, logic [12:0] b_in, logic bi, int stall_max,
                      int hold, string tag);
      int  w = wid[k];
      int  mask = (1 << w) - 1;
      int  a = int'(a_in) & mask;
      int  b = int'(b_in) & mask;
      int  diff = a - b - int'(bi);
      int  ex = diff & ((1 << (w + 1)) - 1);
      int  sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
      int  sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
      int  sres = sa - sb - int'(bi);
      int  exp_ovf = (sres < -(1 << (w - 1)) || sres > (1 << (w - 1)) - 1) ? 1 : 0;
      int  lat = 0;
      int  stall;
      bit  ok;
      send(k, 13'(a), 13'(b), bi, stall_max, tag, ok);
      if (!ok) return;
      while (!ov[k] && lat < 100) begin
         tick();
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'(w));
      stall = (hold > 0) ? hold : int'($urandom_range(0, stall_max));
      for (int s = 0; s < stall; s++) begin
         if (hold > 0) begin
            iv[k] = 1'b1; a_s[k] = 13'($urandom); b_s[k] = 13'($urandom);
         end
         tick();
         if (hold > 0) begin
            chk($sformatf("%s_hold%0d_valid", tag, s), 32'(ov[k]), 1);
            chk($sformatf("%s_hold%0d_in_ready", tag, s), 32'(ir[k]), 0);
            chk($sformatf("%s_hold%0d_d", tag, s), get_d(k), 32'(ex & mask));
            chk($sformatf("%s_hold%0d_bo", tag, s), 32'(bo[k]), 32'(ex >> w));
         end
      end
      iv[k] = 1'b0;
      chk({tag, "_valid"}, 32'(ov[k]), 1);
      chk({tag, "_d"}, get_d(k), 32'(ex & mask));
      chk({tag, "_bo"}, 32'(bo[k]), 32'(ex >> w));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      chk({tag, "_ovf"}, 32'(ovf[k]), 32'(exp_ovf));
`else
      if (exp_ovf > 1) chk({tag, "_ovf_model"}, 32'(exp_ovf), 1);
`endif
      ordy[k] = 1'b1;
      tick();
      ordy[k] = 1'b0;
      chk({tag, "_valid_drop"}, 32'(ov[k]), 0);
      chk({tag, "_in_ready_back"}, 32'(ir[k]), 1);
      $display("txn %s w=%0d a=%0h b=%0h bi=%0d -> d=%0h bo=%0d lat=%0d", tag, w, a, b, bi,
               get_d(k), bo[k], lat);
   endtask

   initial begin
      int  spurious;
      bit  ok;
      rst_n = 1'b0;
      iv = '0; ordy = '0; bi_s = '0;
      for (int k = 0; k < 3; k++) begin
         a_s[k] = '0; b_s[k] = '0;
      end
      repeat (2) tick();
      reset_vals("reset");
      rst_n = 1'b1;
      tick();

      txn(1, 13'h35, 13'h12, 1'b0, 0, 0, "dir_35_12");
      txn(1, 13'h00, 13'h01, 1'b0, 0, 0, "dir_00_01");
      txn(1, 13'h10, 13'h0F, 1'b1, 0, 0, "dir_10_0F_bi");
      txn(1, 13'h00, 13'hFF, 1'b1, 0, 0, "dir_00_FF_bi");
      txn(1, 13'h5A, 13'h21, 1'b0, 0, 5, "backpressure");
      txn(1, 13'hC3, 13'h44, 1'b1, 0, 0, "after_bp");
      txn(0, 13'h0, 13'h1, 1'b0, 0, 0, "w1_0_1");
      txn(2, 13'h1000, 13'h0001, 1'b0, 0, 0, "w13_min");

      // Reset part-way through RUN after a nonzero result is sitting on d_o
      send(1, 13'h55, 13'h22, 1'b0, 0, "rst_mid_run", ok);
      repeat (3) tick();
      #2 rst_n = 1'b0;
      #1 reset_vals("async_reset");
      tick();
      #2 rst_n = 1'b1;
      spurious = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (ov[1]) spurious++;
      end
      chk("no_spurious_valid", 32'(spurious), 0);
      txn(1, 13'h80, 13'h01, 1'b0, 0, 0, "post_reset_80_01");

      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 1000; i++) begin
            txn(k, 13'($urandom), 13'($urandom), 1'($urandom), 2, 0,
                $sformatf("rnd_w%0d_%0d", wid[k], i));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
